// File: rtl/mouse_status_pkg.sv
// Shared types and constants for the mouse-status PIO sequencer.
// Imported by the arbiter, the sequencer top and nothing else.
package mouse_status_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] PIO_STATUS_OFFSET = 2'd0;
    localparam int         AVM_DATA_W        = 32;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mouse_status_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after last_grant,
// wrapping from NREQ-1 back to 0.
module rr_arbiter
    import mouse_status_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    always_comb begin
        int   j;
        logic found;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        j           = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(last_grant_i) + k) % NREQ;
            if (!found && req_i[j]) begin
                found       = 1'b1;
                grant_o[j]  = 1'b1;
                grant_idx_o = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/mouse_status_sequencer.sv
// Arbitrates status requesters onto the PIO register: write, read back,
// retry on mismatch, then acknowledge. Keeps a shadow of the committed value.
module mouse_status_sequencer
    import mouse_status_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int DATA_W    = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        ack,
    output logic                   err,
    output logic                   busy,
    output logic [DATA_W-1:0]      status_shadow,
    output logic [1:0]             avm_address,
    output logic                   avm_chipselect,
    output logic                   avm_write_n,
    output logic [AVM_DATA_W-1:0]  avm_writedata,
    input  logic [AVM_DATA_W-1:0]  avm_readdata
);

    localparam int               IDX_W      = idx_w(NREQ);
    localparam logic [3:0]       RETRY_LAST = 4'(MAX_RETRY - 1);
    localparam logic [IDX_W-1:0] LAST_INIT  = IDX_W'(NREQ - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cur_q, cur_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [DATA_W-1:0]  cur_data_q, cur_data_d;
    logic [DATA_W-1:0]  shadow_q, shadow_d;
    logic [3:0]         retry_q, retry_d;
    logic               err_flag_q, err_flag_d;

    logic [NREQ-1:0]    gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic [DATA_W-1:0]  gnt_data;
    logic               rd_ok;
    logic               unused_rd;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i        (req),
        .last_grant_i (last_q),
        .grant_o      (gnt),
        .grant_idx_o  (gnt_idx)
    );

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) gnt_data = gnt_data | req_data[i*DATA_W +: DATA_W];
        end
    end

    // Only the PIO port width takes part in the readback compare.
    assign rd_ok     = (avm_readdata[DATA_W-1:0] == cur_data_q);
    assign unused_rd = ^avm_readdata[AVM_DATA_W-1:DATA_W];

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        last_d     = last_q;
        cur_data_d = cur_data_q;
        shadow_d   = shadow_q;
        retry_d    = retry_q;
        err_flag_d = err_flag_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    cur_d      = gnt_idx;
                    cur_data_d = gnt_data;
                    retry_d    = '0;
                    state_d    = WRITE;
                end
            end
            WRITE: state_d = READ;
            READ: begin
                if (rd_ok) begin
                    shadow_d = cur_data_q;
                    state_d  = DONE;
                end else if (retry_q == RETRY_LAST) begin
                    err_flag_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    retry_d = retry_q + 4'd1;
                    state_d = WRITE;
                end
            end
            DONE: begin
                last_d     = cur_q;
                err_flag_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            last_q     <= LAST_INIT;
            cur_data_q <= '0;
            shadow_q   <= '0;
            retry_q    <= '0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            last_q     <= last_d;
            cur_data_q <= cur_data_d;
            shadow_q   <= shadow_d;
            retry_q    <= retry_d;
            err_flag_q <= err_flag_d;
        end
    end

    always_comb begin
        ack = '0;
        if (state_q == DONE) ack[cur_q] = 1'b1;
    end

    assign err            = (state_q == DONE) && err_flag_q;
    assign busy           = (state_q != IDLE);
    assign status_shadow  = shadow_q;
    assign avm_address    = PIO_STATUS_OFFSET;
    assign avm_chipselect = (state_q == WRITE) || (state_q == READ);
    assign avm_write_n    = (state_q != WRITE);
    assign avm_writedata  = (state_q == WRITE) ? AVM_DATA_W'(cur_data_q) : '0;

endmodule

// File: tb/tb_mouse_status_sequencer.sv
// Scoreboard bench for mouse_status_sequencer: a transaction-level model
// predicts each ack (who, when, err, shadow); a monitor checks it.
module tb_mouse_status_sequencer;

    localparam int NREQ      = 2;
    localparam int DATA_W    = 2;
    localparam int MAX_RETRY = 3;

    logic                   clk     = 1'b0;
    logic                   reset_r = 1'b1;
    logic [NREQ-1:0]        req_r   = '0;
    logic [NREQ*DATA_W-1:0] data_r  = '0;
    logic [NREQ-1:0]        ack;
    logic                   err;
    logic                   busy;
    logic [DATA_W-1:0]      status_shadow;
    logic [1:0]             avm_address;
    logic                   avm_chipselect;
    logic                   avm_write_n;
    logic [31:0]            avm_writedata;
    logic [31:0]            avm_readdata;

    logic [DATA_W-1:0] pio_q       = '0;
    int                reads_seen  = 0;
    int                fault_until = 0;
    logic [31:0]       garbage     = '0;

    int   cyc   = 0;
    logic rst_d = 1'b1;

    typedef struct {
        int                cyc;
        int                idx;
        bit                err;
        logic [DATA_W-1:0] shadow;
    } exp_t;

    exp_t              exp_q[$];
    int                m_free    = 0;
    int                m_last    = NREQ - 1;
    int                m_gnt_cyc = -10;
    int                m_ack_cyc = -10;
    logic [DATA_W-1:0] m_shadow  = '0;
    logic [DATA_W-1:0] m_wdata   = '0;

    int next_nbad = -1;
    int mode      = 0;
    int gap[NREQ];
    int rst_left  = 0;
    int n_chk     = 0;
    int n_err     = 0;
    int n_served  = 0;

    mouse_status_sequencer #(
        .NREQ      (NREQ),
        .DATA_W    (DATA_W),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk            (clk),
        .reset          (reset_r),
        .req            (req_r),
        .req_data       (data_r),
        .ack            (ack),
        .err            (err),
        .busy           (busy),
        .status_shadow  (status_shadow),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= reset_r;
    end

    // Behavioural PIO: zero-wait register; readback corrupted while faults remain.
    always @(posedge clk) begin
        if (reset_r) pio_q <= '0;
        else if (avm_chipselect && !avm_write_n) pio_q <= avm_writedata[DATA_W-1:0];
        if (avm_chipselect && avm_write_n) reads_seen <= reads_seen + 1;
    end

    assign avm_readdata = {garbage[31:DATA_W],
                           (reads_seen < fault_until) ? ~pio_q : pio_q};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_free    = 0;
        m_last    = NREQ - 1;
        m_gnt_cyc = -10;
        m_ack_cyc = -10;
        m_shadow  = '0;
    endtask

    task automatic grant();
        int   g;
        int   j;
        int   r;
        int   nbad;
        int   att;
        exp_t e;
        g = -1;
        for (int k = 1; k <= NREQ; k++) begin
            j = (m_last + k) % NREQ;
            if (g < 0 && req_r[j]) g = j;
        end
        if (next_nbad >= 0) begin
            nbad      = next_nbad;
            next_nbad = -1;
        end else if (mode == 2) begin
            r    = $urandom_range(0, 9);
            nbad = (r < 6) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : $urandom_range(3, 5);
        end else begin
            nbad = 0;
        end
        att     = (nbad + 1 > MAX_RETRY) ? MAX_RETRY : nbad + 1;
        e.err   = (nbad >= MAX_RETRY);
        m_wdata = data_r[g*DATA_W +: DATA_W];
        if (!e.err) m_shadow = m_wdata;
        e.cyc     = cyc + 2 * att + 1;
        e.idx     = g;
        e.shadow  = m_shadow;
        m_gnt_cyc = cyc;
        m_ack_cyc = e.cyc;
        m_free    = e.cyc + 1;
        m_last    = g;
        fault_until = reads_seen + nbad;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        if (reset_r) model_reset();
        reset_r = (rst_left > 0);
        if (rst_left > 0) rst_left--;
        garbage = $urandom;
    endtask

    task automatic post();
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) begin
                req_r[i] = 1'b0;
                gap[i]   = (mode == 2) ? int'($urandom_range(1, 6)) : 1;
            end else if (!req_r[i] && mode != 0) begin
                if (gap[i] > 0) gap[i]--;
                else if (mode == 1 || $urandom_range(0, 3) == 0) begin
                    req_r[i] = 1'b1;
                    data_r[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                end
            end
        end
        if (!reset_r && cyc >= m_free && req_r != '0) grant();
    endtask

    task automatic step();
        tick();
        post();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || cyc < m_free || req_r != '0) && n < budget) begin
            step();
            n++;
        end
        if (exp_q.size() != 0 || req_r != '0) begin
            n_chk++;
            n_err++;
            $display("FAIL timeout: %0d acks pending, req=%b after %0d cycles",
                     exp_q.size(), req_r, n);
            exp_q.delete();
            req_r = '0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cs"},     32'(avm_chipselect), 32'd0);
        chk({tag, "_wn"},     32'(avm_write_n),    32'd1);
        chk({tag, "_wdata"},  avm_writedata,       32'd0);
        chk({tag, "_addr"},   32'(avm_address),    32'd0);
        chk({tag, "_busy"},   32'(busy),           32'd0);
        chk({tag, "_ack"},    32'(ack),            32'd0);
        chk({tag, "_err"},    32'(err),            32'd0);
        chk({tag, "_shadow"}, 32'(status_shadow),  32'd0);
    endtask

    task automatic apply_reset();
        rst_left = 2;
        step();
        step();
        check_reset_outputs("reset");
    endtask

    task automatic single(input int idx, input logic [DATA_W-1:0] d, input int nbad);
        tick();
        next_nbad = nbad;
        req_r[idx] = 1'b1;
        data_r[idx*DATA_W +: DATA_W] = d;
        post();
        wait_done(60);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_d) begin
            chk("busy", 32'(busy), {31'd0, (cyc > m_gnt_cyc && cyc <= m_ack_cyc)});
            if (avm_chipselect && !avm_write_n) begin
                chk("writedata", avm_writedata, 32'(m_wdata));
                chk("address", 32'(avm_address), 32'd0);
            end
            if (ack != '0) begin
                if (exp_q.size() == 0) begin
                    chk("ack_unexpected", 32'(ack), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_vec", 32'(ack), 32'd1 << e.idx);
                    chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                    chk("ack_err", 32'(err), 32'(e.err));
                    chk("ack_shadow", 32'(status_shadow), 32'(e.shadow));
                    n_served++;
                end
            end else begin
                chk("err_no_ack", 32'(err), 32'd0);
                if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    chk("ack_missing", 32'(ack), 32'd1 << e.idx);
                end
            end
        end
    end

    initial begin
        int start;
        int n;

        rst_left = 2;
        step();
        step();
        check_reset_outputs("por");

        single(0, 2'b10, 0);
        chk("single_shadow", 32'(status_shadow), 32'h2);

        apply_reset();
        tick();
        next_nbad = 0;
        req_r  = 2'b11;
        data_r = {2'b11, 2'b01};
        post();
        wait_done(60);
        chk("simul_shadow", 32'(status_shadow), 32'h3);

        single(0, 2'b01, 3);
        chk("fault_shadow", 32'(status_shadow), 32'h3);

        single(1, 2'b10, 1);
        chk("transient_shadow", 32'(status_shadow), 32'h2);

        mode  = 1;
        start = n_served;
        n     = 0;
        while (n_served < start + 8 && n < 200) begin
            step();
            n++;
        end
        chk("fair_services", 32'(n_served - start), 32'd8);
        mode = 0;
        wait_done(60);

        single(0, 2'b01, 0);
        chk("pre_reset_shadow", 32'(status_shadow), 32'h1);

        tick();
        next_nbad = 0;
        req_r[0]  = 1'b1;
        data_r[DATA_W-1:0] = 2'b11;
        post();
        tick();
        chk("mid_write_cs", 32'(avm_chipselect), 32'd1);
        chk("mid_write_wn", 32'(avm_write_n), 32'd0);
        reset_r = 1'b1;
        post();
        tick();
        chk("mid_reset_cs", 32'(avm_chipselect), 32'd0);
        chk("mid_reset_wn", 32'(avm_write_n), 32'd1);
        chk("mid_reset_busy", 32'(busy), 32'd0);
        chk("mid_reset_ack", 32'(ack), 32'd0);
        chk("mid_reset_shadow", 32'(status_shadow), 32'd0);
        post();
        wait_done(60);
        chk("after_reset_shadow", 32'(status_shadow), 32'h3);

        mode = 2;
        repeat (3000) step();
        mode = 0;
        wait_done(400);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mouse_status_sequencer.md
# mouse_status_sequencer

Controller that owns the 2-bit mouse-status PIO output register and shares it between several hardware requesters (USB HID decoder, game-logic overrides, debug). It round-robin arbitrates requests and issues a zero-wait Avalon-MM write to PIO offset 0. It then reads the register back, compares, retries on mismatch and acknowledges the requester. It sits between the requesters and the PIO slave port inside the SoC fabric, and keeps a shadow copy of the last committed status.

## Interface
- NREQ, 2: number of requesters (2..8).
- DATA_W, 2: status width; equals the PIO port width.
- MAX_RETRY, 3: write/readback attempts before error (1..15).
- clk  in  1: system clock.
- reset  in  1: synchronous, active-high reset.
- req  in  NREQ: per-requester request level; held until that requester's ack.
- req_data  in  NREQ*DATA_W: status values, requester i at bits [i*DATA_W +: DATA_W]; must be stable while req[i] is high.
- ack  out  NREQ: one-cycle pulse to the served requester on completion (success or error).
- err  out  1: one-cycle pulse, coincident with ack, when readback failed MAX_RETRY times.
- busy  out  1: high in any state other than IDLE.
- status_shadow  out  DATA_W: last successfully committed value.
- avm_address  out  2: PIO register offset; always 0.
- avm_chipselect  out  1: PIO chip select.
- avm_write_n  out  1: active-low write strobe.
- avm_writedata  out  32: req_data of the granted requester, zero-extended.
- avm_readdata  in  32: PIO read data; combinational from the slave with zero wait states.

## Operation
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE
  - If any req bit is high, select the next requesting index after last_grant (round-robin, wrapping from NREQ-1 to 0).
  - Latch that index into cur and its req_data into cur_data.
  - Clear retry_cnt and go to WRITE.
  - If no req bit is high, stay in IDLE.
- WRITE
  - Drive chipselect=1, write_n=0, address=0, writedata={zeros, cur_data}.
  - Always advance to READ after one cycle.
- READ
  - Drive chipselect=1, write_n=1, address=0.
  - Sample avm_readdata[DATA_W-1:0] at the clock edge and compare it with cur_data. Upper bits are ignored.
  - Match: update status_shadow to cur_data, go to DONE.
  - Mismatch with retry_cnt+1 < MAX_RETRY: increment retry_cnt, return to WRITE.
  - Mismatch with retry_cnt+1 = MAX_RETRY: go to DONE with err_flag set. status_shadow is unchanged.
- DONE
  - ack[cur]=1 for exactly one cycle; err=err_flag.
  - Set last_grant to cur, clear err_flag, go to IDLE.
- Requesters drop req on the edge after ack, so IDLE never re-serves a request that was just completed.
- Outside WRITE and READ: chipselect=0, write_n=1, writedata=0.
- A req that rises while busy waits; it is never lost.
- A req that is withdrawn before grant is simply not served.
- Requests are not merged. Each granted request performs its own write, even if its value equals status_shadow.

## Timing
- Every output is decoded from registered state or registers; there are no combinational paths from req or readdata to outputs.
- Reset values:
  - State IDLE; ack=0; err=0; busy=0.
  - status_shadow=0, matching the PIO reset value.
  - avm_chipselect=0, avm_write_n=1, avm_writedata=0, avm_address=0.
  - last_grant=NREQ-1, so requester 0 wins first.
- Latency with no retries: req seen high in IDLE at cycle 0 → WRITE at cycle 1 → READ at cycle 2 → DONE/ack at cycle 3 → IDLE at cycle 4.
- Each retry adds 2 cycles. Worst case from grant to ack is 2*MAX_RETRY+1 cycles.
- Back-to-back service: the next grant is decided in the IDLE cycle after DONE. Alternating service between two requesters therefore gives a 4-cycle period.
- Reset asserted in any state: at the next edge, go to IDLE and return all outputs to their reset values. No ack is issued for the aborted request; the requester keeps req high and is re-arbitrated.
- Simultaneous requests: exactly one grant per IDLE decision, chosen by round-robin order.

## Structure
- Package mouse_status_pkg holds:
  - the state enum (IDLE, WRITE, READ, DONE);
  - localparam PIO_STATUS_OFFSET = 2'd0;
  - localparam AVM_DATA_W = 32.
- One sub-module, rr_arbiter: parameterised NREQ; takes the req vector and last_grant; returns a one-hot grant and its encoded index. It is purely combinational.
- The FSM, the data latches, retry_cnt and status_shadow live in mouse_status_sequencer.

## Test plan
- Single request: req[0] with data 2'b10, behavioural PIO model → writedata=0x2 at cycle 1, read at cycle 2, ack[0] at cycle 3, err=0, status_shadow=2'b10.
- Simultaneous requests after reset: req=2'b11 with data 01 and 11 → requester 0 is served first (ack[0] at cycle 3), then requester 1 (ack[1] at cycle 7), status_shadow=2'b11.
- Fairness: both requesters reassert continuously for 8 services → ack alternates 0,1,0,1…; no requester is served twice in a row.
- Readback fault: the model forces readdata=0 while data is 2'b01, MAX_RETRY=3 → 3 write/read pairs, then ack[0] and err both high at cycle 7, status_shadow unchanged.
- Transient fault: first readback is wrong, second is correct → ack at cycle 5, err=0, shadow updated.
- Reset mid-operation: reset asserted during WRITE → next cycle chipselect=0, write_n=1, busy=0, no ack, shadow=0. After release, the held req is served with the normal 3-cycle latency.
